// File: rtl/mips_pkg.sv
// Shared constants for the MIPS memory stage: default memory map, I/O window offsets
// and the decoded-region type used by the data memory address decoder.
package mips_pkg;

  localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] IO_BASE_DEF   = 32'hFFFF_0000;

  localparam logic [31:0] PORTOUT_OFS = 32'h0000_0000;
  localparam logic [31:0] PORTIN_OFS  = 32'h0000_0004;
  localparam logic [31:0] PORTEVT_OFS = 32'h0000_0008;
  localparam int          WORD_BYTES  = 4;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_PORTOUT,
    REG_PORTIN,
    REG_PORTEVT
  } memRegion_t;

endpackage

// File: rtl/port_in_sync.sv
// Two-flop synchronizer for the external input pins, plus a sticky change-event flag
// raised whenever the synchronized value differs from the previous sample.
module port_in_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] portIn,
  input  logic         clr,
  output logic [W-1:0] sync,
  output logic         evt
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;
  logic         changeSeen;

  assign changeSeen = (sync2 != prev);

  // A change detected on the same edge as a clear must not be lost, so set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= portIn;
      sync2 <= sync1;
      prev  <= sync2;
      if (changeSeen)
        evt <= 1'b1;
      else if (clr)
        evt <= 1'b0;
    end
  end

  assign sync = sync2;

endmodule

// File: rtl/mips_data_memory_io.sv
// Memory stage: word-addressed data RAM plus a small memory-mapped I/O window
// (output port, synchronized input port, sticky input-change event).
module mips_data_memory_io
  import mips_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEF,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        AddrError
);

  localparam int IDXW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [32:0] RAM_END = {1'b0, DATA_BASE} + 33'(WORD_BYTES * MEMORY_DEPTH);

  logic [31:0]     ram [MEMORY_DEPTH];
  logic [31:0]     ramOffset;
  logic [IDXW-1:0] ramIndex;
  logic            ramHit;
  logic            misaligned;
  memRegion_t      region;
  logic            accessOk;
  logic            evtClr;
  logic [7:0]      portInSync;
  logic            portEvt;

  // The upper bound is compared in 33 bits so the RAM window can never wrap around.
  assign ramHit    = (Address >= DATA_BASE) && ({1'b0, Address} < RAM_END);
  assign ramOffset = Address - DATA_BASE;
  assign ramIndex  = IDXW'(ramOffset >> 2);
  assign misaligned = |Address[1:0];

  always_comb begin
    region = REG_NONE;
    if (ramHit)
      region = REG_RAM;
    else if (Address == IO_BASE + PORTOUT_OFS)
      region = REG_PORTOUT;
    else if (Address == IO_BASE + PORTIN_OFS)
      region = REG_PORTIN;
    else if (Address == IO_BASE + PORTEVT_OFS)
      region = REG_PORTEVT;
  end

  assign AddrError = (MemRead | MemWrite) & (misaligned | (region == REG_NONE));
  assign accessOk  = ~misaligned & (region != REG_NONE);
  assign evtClr    = MemRead & accessOk & (region == REG_PORTEVT);

  // RAM has no reset; a store that coincides with reset is simply dropped.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && accessOk && (region == REG_RAM))
      ram[ramIndex] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset)
      PortOut <= '0;
    else if (MemWrite && accessOk && (region == REG_PORTOUT))
      PortOut <= WriteData;
  end

  port_in_sync #(.W(8)) uSync (
    .clk    (clk),
    .reset  (reset),
    .portIn (PortIn),
    .clr    (evtClr),
    .sync   (portInSync),
    .evt    (portEvt)
  );

  always_comb begin
    ReadData = '0;
    if (MemRead && accessOk) begin
      unique case (region)
        REG_RAM:     ReadData = ram[ramIndex];
        REG_PORTOUT: ReadData = PortOut;
        REG_PORTIN:  ReadData = {24'b0, portInSync};
        REG_PORTEVT: ReadData = {31'b0, portEvt};
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_memory_io.sv
// Directed self-checking bench for mips_data_memory_io; expected load data is queued
// when each access is driven and popped when the combinational result is sampled.
module tb_mips_data_memory_io;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        AddrError;

  int total = 0;
  int bad = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;

  always #5 clk = ~clk;

  mips_data_memory_io dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .AddrError (AddrError)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected load result for the access just driven, then compare after settling.
  task automatic loadCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    expQ.push_back(exp);
    #1;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s: observed=empty expected=entry", tag);
    end else begin
      expVal = expQ.pop_front();
      checkOutput(tag, ReadData, expVal);
    end
  endtask

  initial begin
    reset  = 1'b1;
    PortIn = 8'h00;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step();
    checkOutput("resetPortOut", PortOut, 32'h0);
    loadCheck("resetEvt", IO_BASE_DEF + PORTEVT_OFS, 32'h0);
    reset = 1'b0;
    step();

    // 1: store then load RAM
    applyStimulus(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    #1 checkOutput("swErr", {31'b0, AddrError}, 32'h0);
    step();
    loadCheck("lwRam", 32'h1001_0004, 32'hDEAD_BEEF);
    checkOutput("lwErr", {31'b0, AddrError}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1001_0000, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 1'b1, 32'h1001_00FC, 32'hCAFE_F00D);
    step();
    loadCheck("lwLastWord", 32'h1001_00FC, 32'hCAFE_F00D);
    loadCheck("lwWord0", 32'h1001_0000, 32'h1234_5678);

    // 2: PortOut store and reset
    applyStimulus(1'b0, 1'b1, IO_BASE_DEF + PORTOUT_OFS, 32'h0000_00A5);
    step();
    checkOutput("portOutA5", PortOut, 32'hA5);
    loadCheck("lwPortOut", IO_BASE_DEF + PORTOUT_OFS, 32'hA5);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("portOutReset", PortOut, 32'h0);

    // 3: synchronizer latency and sticky event
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    PortIn = 8'h3C;
    step();
    loadCheck("portIn1Edge", IO_BASE_DEF + PORTIN_OFS, 32'h00);
    step();
    loadCheck("portIn2Edge", IO_BASE_DEF + PORTIN_OFS, 32'h3C);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    loadCheck("evtSet", IO_BASE_DEF + PORTEVT_OFS, 32'h1);
    step();
    loadCheck("evtCleared", IO_BASE_DEF + PORTEVT_OFS, 32'h0);

    // 4: set lands on a clearing edge
    PortIn = 8'hC3;
    step();
    step();
    loadCheck("evtBeforeSet", IO_BASE_DEF + PORTEVT_OFS, 32'h0);
    step();
    loadCheck("evtSetWins", IO_BASE_DEF + PORTEVT_OFS, 32'h1);
    step();
    loadCheck("evtClearAfter", IO_BASE_DEF + PORTEVT_OFS, 32'h0);

    // 5: misaligned and unmapped accesses
    applyStimulus(1'b0, 1'b1, 32'h1001_0002, 32'h0BAD_0BAD);
    #1 checkOutput("misalignErr", {31'b0, AddrError}, 32'h1);
    step();
    applyStimulus(1'b0, 1'b1, 32'h1001_0100, 32'h0BAD_0BAD);
    #1 checkOutput("unmappedErr", {31'b0, AddrError}, 32'h1);
    step();
    applyStimulus(1'b0, 1'b1, 32'h1000_FFFC, 32'h0BAD_0BAD);
    #1 checkOutput("belowBaseErr", {31'b0, AddrError}, 32'h1);
    step();
    loadCheck("lwMisaligned", 32'h1001_0002, 32'h0);
    checkOutput("lwMisalignErr", {31'b0, AddrError}, 32'h1);
    loadCheck("lwUnmapped", 32'h1001_0100, 32'h0);
    loadCheck("ramWord0Kept", 32'h1001_0000, 32'h1234_5678);
    loadCheck("ramLastKept", 32'h1001_00FC, 32'hCAFE_F00D);

    // 6: MemRead low, read-only port writes, read-during-write, reset-dropped store
    applyStimulus(1'b0, 1'b0, 32'h1001_0004, 32'h0);
    #1 checkOutput("noReadZero", ReadData, 32'h0);
    checkOutput("noAccessErr", {31'b0, AddrError}, 32'h0);
    applyStimulus(1'b0, 1'b1, IO_BASE_DEF + PORTOUT_OFS, 32'h77);
    step();
    applyStimulus(1'b0, 1'b1, IO_BASE_DEF + PORTIN_OFS, 32'h55);
    #1 checkOutput("roWriteErr", {31'b0, AddrError}, 32'h0);
    step();
    checkOutput("portOutKept", PortOut, 32'h77);

    applyStimulus(1'b1, 1'b1, 32'h1001_0004, 32'h0F0F_0F0F);
    expQ.push_back(32'hDEAD_BEEF);
    #1 expVal = expQ.pop_front();
    checkOutput("rdwPreEdge", ReadData, expVal);
    step();
    loadCheck("rdwPostEdge", 32'h1001_0004, 32'h0F0F_0F0F);

    applyStimulus(1'b0, 1'b1, 32'h1001_0008, 32'h2222_2222);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, IO_BASE_DEF + PORTOUT_OFS, 32'h99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("resetDropsPortOut", PortOut, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1001_0008, 32'h1111_1111);
    step();
    applyStimulus(1'b0, 1'b1, 32'h1001_0008, 32'h3333_3333);
    reset = 1'b1;
    step();
    reset = 1'b0;
    loadCheck("resetDropsRam", 32'h1001_0008, 32'h1111_1111);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
